// File: rtl/mem_stage_sram_burst.sv
// mem_stage_sram_burst: MIPS MEM stage that splits one CPU load/store into
// BEATS narrow accesses on an asynchronous SRAM, each beat held for WAIT+1
// cycles, and freezes the rest of the pipeline until the word is complete.
module mem_stage_sram_burst #(
  parameter int DATA_W    = 32,
  parameter int DQ_W      = 16,
  parameter int ADDR_W    = 18,
  parameter int WAIT      = 1,
  parameter int BASE_ADDR = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       alu_result,
  input  logic [DATA_W-1:0] st_val,
  input  logic              wb_en_in,
  output logic [DATA_W-1:0] mem_read_value,
  output logic              wb_en_out,
  output logic              freeze,
  inout  wire  [DQ_W-1:0]   SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N
);

  localparam int BEATS   = DATA_W / DQ_W;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int OFF_W   = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                is_write;
  logic [ADDR_W-1:0]   word_idx;
  logic [DATA_W-1:0]   st_lat;
  logic [DATA_W-1:0]   rd_buf;
  logic [DATA_W-1:0]   rd_word;
  logic [BEAT_W-1:0]   beat;
  logic [3:0]          wait_cnt;
  logic [OFF_W-1:0]    lane_lsb;
  logic [31:0]         byte_off;
  logic                request;
  logic                last_wait;
  logic                last_cycle;
  logic                in_access;

  assign request    = mem_r_en | mem_w_en;
  assign byte_off   = alu_result - 32'(BASE_ADDR);
  assign lane_lsb   = OFF_W'(beat * DQ_W);
  assign in_access  = (state == ACCESS);
  assign last_wait  = (wait_cnt == 4'(WAIT));
  assign last_cycle = in_access && last_wait && (beat == BEAT_W'(BEATS - 1));

  // Byte enables and chip enable are only released while reset is held.
  assign SRAM_UB_N = ~rst;
  assign SRAM_LB_N = ~rst;
  assign SRAM_CE_N = ~rst;

  // Address and DQ derive from the state register, so an asynchronous reset
  // releases the bus and the strobes without waiting for a clock edge.
  assign SRAM_ADDR = in_access ? (word_idx * ADDR_W'(BEATS)) + ADDR_W'(beat) : '0;
  assign SRAM_DQ   = (in_access && is_write) ? st_lat[lane_lsb +: DQ_W] : 'z;

  assign wb_en_out = wb_en_in & ~freeze;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and strobes; requests arriving in DONE are deliberately ignored.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    state_nxt = state;
    freeze    = 1'b0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    case (state)
      IDLE: begin
        freeze = request;
        if (request) state_nxt = ACCESS;
      end
      ACCESS: begin
        freeze    = 1'b1;
        SRAM_WE_N = ~is_write;
        SRAM_OE_N = is_write;
        if (last_cycle) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read word as it will look once the lane currently on the bus is merged.
  always_comb begin
    rd_word                      = rd_buf;
    rd_word[lane_lsb +: DQ_W]    = SRAM_DQ;
  end

  // Request latch, beat/wait counters, read assembly and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_write       <= 1'b0;
      word_idx       <= '0;
      st_lat         <= '0;
      rd_buf         <= '0;
      beat           <= '0;
      wait_cnt       <= '0;
      mem_read_value <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            // A simultaneous read and write is performed as a write.
            is_write <= mem_w_en;
            word_idx <= ADDR_W'(byte_off >> BYTE_SH);
            st_lat   <= st_val;
            beat     <= '0;
            wait_cnt <= '0;
          end
        end
        ACCESS: begin
          if (!is_write && last_wait) rd_buf <= rd_word;
          if (last_cycle) begin
            if (!is_write) mem_read_value <= rd_word;
            beat     <= '0;
            wait_cnt <= '0;
          end else if (last_wait) begin
            beat     <= beat + 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_burst.sv
// tb_mem_stage_sram_burst: three instances (WAIT = 1, 0, 3) on 32/16/18
// geometry, each with its own behavioural SRAM; expected values come from a
// word-level memory model and cycle counts derived from BEATS and WAIT.
`timescale 1ns/1ps
module tb_mem_stage_sram_burst;

  localparam int AW = 18;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_en   [NI];
  logic        w_en   [NI];
  logic        wb_in  [NI];
  logic [31:0] alu    [NI];
  logic [31:0] st     [NI];
  logic [31:0] rd_val [NI];
  logic        wb_out [NI];
  logic        frz    [NI];
  logic        ub_n   [NI];
  logic        lb_n   [NI];
  logic        ce_n   [NI];
  logic        we_n   [NI];
  logic        oe_n   [NI];
  logic [AW-1:0] addr [NI];
  logic [15:0] dq_obs [NI];

  int n_checks = 0;
  int n_fail   = 0;
  int last_frz_len;

  // Word-level reference: key = instance * 2^20 + (word index mod 2^17).
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    tri1 [15:0]  dq;
    logic [15:0] mem [2**AW];

    mem_stage_sram_burst #(
      .DATA_W(32), .DQ_W(16), .ADDR_W(AW), .WAIT(W), .BASE_ADDR(1024)
    ) u_dut (
      .clk(clk), .rst(rst),
      .mem_r_en(r_en[g]), .mem_w_en(w_en[g]), .alu_result(alu[g]),
      .st_val(st[g]), .wb_en_in(wb_in[g]),
      .mem_read_value(rd_val[g]), .wb_en_out(wb_out[g]), .freeze(frz[g]),
      .SRAM_DQ(dq), .SRAM_ADDR(addr[g]),
      .SRAM_UB_N(ub_n[g]), .SRAM_LB_N(lb_n[g]), .SRAM_CE_N(ce_n[g]),
      .SRAM_WE_N(we_n[g]), .SRAM_OE_N(oe_n[g])
    );

    assign dq        = (oe_n[g] == 1'b0) ? mem[addr[g]] : 16'bz;
    assign dq_obs[g] = dq;

    always @(posedge clk) begin
      if (we_n[g] == 1'b0) mem[addr[g]] <= dq;
    end
  end

  function automatic int wait_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
  endfunction

  function automatic int word_key(input int g, input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'd1024) / 4;
    return g * (1 << 20) + int'(w % 32'(1 << 17));
  endfunction

  function automatic logic [AW-1:0] sram_addr_of(input logic [31:0] a, input int beat);
    logic [31:0] w;
    w = (a - 32'd1024) / 4;
    return AW'((w * 2 + 32'(beat)) % 32'(1 << AW));
  endfunction

  // One request held from the current negedge until the DONE cycle.
  task automatic run_access(input int g, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d, input logic wb);
    int          w, cyc, c, beat, key;
    logic [31:0] word_e, rd_e;
    logic [15:0] slice_e;
    logic [35:0] obs, exp_v;
    bit          done;
    w      = wait_of(g);
    cyc    = 2 * (w + 1);
    key    = word_key(g, a);
    word_e = wr ? d : (ref_mem.exists(key) ? ref_mem[key] : 32'h0);
    rd_e   = wr ? ref_rd[g] : word_e;
    r_en[g] = rd; w_en[g] = wr; alu[g] = a; st[g] = d; wb_in[g] = wb;
    c = 0;
    done = 1'b0;
    while (!done) begin
      #1;
      if (frz[g] === 1'b1) begin
        if (c == 0) begin
          n_checks++;
          if ({we_n[g], oe_n[g]} !== 2'b11) begin
            n_fail++;
            $display("FAIL idle_strobes g%0d: got %b expected 11", g, {we_n[g], oe_n[g]});
          end
        end else if (c <= cyc) begin
          beat    = (c - 1) / (w + 1);
          slice_e = (beat == 0) ? word_e[15:0] : word_e[31:16];
          obs     = {we_n[g], oe_n[g], addr[g], dq_obs[g]};
          exp_v   = {~wr, wr, sram_addr_of(a, beat), slice_e};
          n_checks++;
          if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL beat g%0d cyc%0d {we,oe,addr,dq}: got %h expected %h", g, c, obs, exp_v);
          end
        end
        n_checks++;
        if (wb_out[g] !== 1'b0) begin
          n_fail++;
          $display("FAIL wb_frozen g%0d cyc%0d: got %b expected 0", g, c, wb_out[g]);
        end
        c++;
        if (c > cyc + 4) begin
          n_fail++;
          $display("FAIL freeze_timeout g%0d: got >%0d cycles expected %0d", g, cyc + 4, cyc + 1);
          done = 1'b1;
        end
      end else begin
        n_checks++;
        if (c != cyc + 1) begin
          n_fail++;
          $display("FAIL freeze_len g%0d: got %0d expected %0d", g, c, cyc + 1);
        end
        n_checks++;
        if ({we_n[g], oe_n[g], dq_obs[g]} !== {2'b11, 16'hFFFF}) begin
          n_fail++;
          $display("FAIL done_bus g%0d: got %h expected 3ffff", g, {we_n[g], oe_n[g], dq_obs[g]});
        end
        n_checks++;
        if (rd_val[g] !== rd_e) begin
          n_fail++;
          $display("FAIL read_value g%0d a=%h: got %h expected %h", g, a, rd_val[g], rd_e);
        end
        n_checks++;
        if (wb_out[g] !== wb) begin
          n_fail++;
          $display("FAIL wb_done g%0d: got %b expected %b", g, wb_out[g], wb);
        end
        done = 1'b1;
      end
      @(negedge clk);
    end
    last_frz_len = c;
    if (wr) ref_mem[key] = d;
    else    ref_rd[g]    = word_e;
  endtask

  task automatic idle(input int g);
    r_en[g] = 1'b0; w_en[g] = 1'b0; wb_in[g] = 1'b0;
    #1;
    n_checks++;
    if (frz[g] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_freeze g%0d: got %b expected 0", g, frz[g]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int g = 0; g < NI; g++) wb_in[g] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      n_checks++;
      if ({we_n[g], oe_n[g], dq_obs[g], addr[g]} !== {2'b11, 16'hFFFF, 18'h0}) begin
        n_fail++;
        $display("FAIL reset_bus g%0d: got %h expected %h", g,
                 {we_n[g], oe_n[g], dq_obs[g], addr[g]}, {2'b11, 16'hFFFF, 18'h0});
      end
      n_checks++;
      if ({rd_val[g], frz[g], wb_out[g]} !== {32'h0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_out g%0d {rd,frz,wb}: got %h expected %h", g,
                 {rd_val[g], frz[g], wb_out[g]}, {32'h0, 1'b0, 1'b1});
      end
      n_checks++;
      if ({ub_n[g], lb_n[g], ce_n[g]} !== 3'b111) begin
        n_fail++;
        $display("FAIL reset_en g%0d: got %b expected 111", g, {ub_n[g], lb_n[g], ce_n[g]});
      end
    end
    rst = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NI; g++) wb_in[g] = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      n_checks++;
      if ({ub_n[g], lb_n[g], ce_n[g], wb_out[g], frz[g]} !== 5'b0) begin
        n_fail++;
        $display("FAIL run_idle g%0d {ub,lb,ce,wb,frz}: got %b expected 00000", g,
                 {ub_n[g], lb_n[g], ce_n[g], wb_out[g], frz[g]});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_store_load();
    run_access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b1);
    idle(0);
    n_checks++;
    if ({gi[0].mem[3], gi[0].mem[2]} !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sram_content: got %h expected deadbeef", {gi[0].mem[3], gi[0].mem[2]});
    end
    run_access(0, 1'b1, 1'b0, 32'd1028, 32'h0, 1'b1);
    idle(0);
  endtask

  task automatic test_wait_sweep();
    logic [31:0] a, d;
    for (int g = 1; g < NI; g++) begin
      a = 32'd1024 + 4 * $urandom_range(0, 255);
      d = $urandom();
      run_access(g, 1'b0, 1'b1, a, d, 1'b0);
      idle(g);
      run_access(g, 1'b1, 1'b0, a, 32'h0, 1'b1);
      idle(g);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    int          total;
    a = 32'd1024 + 4 * $urandom_range(8, 200);
    run_access(0, 1'b0, 1'b1, a, $urandom(), 1'b0);
    total = last_frz_len;
    run_access(0, 1'b1, 1'b0, a, 32'h0, 1'b1);
    total += last_frz_len;
    n_checks++;
    if (total != 10) begin
      n_fail++;
      $display("FAIL b2b_frozen: got %0d expected 10", total);
    end
    idle(0);
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] old;
    old = ref_mem[word_key(0, 32'd1028)];
    r_en[0] = 1'b0; w_en[0] = 1'b1; alu[0] = 32'd1028; st[0] = 32'h12345678; wb_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({we_n[0], addr[0]} !== {1'b0, 18'd3}) begin
      n_fail++;
      $display("FAIL mid_beat1: got %h expected %h", {we_n[0], addr[0]}, {1'b0, 18'd3});
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({we_n[0], oe_n[0], dq_obs[0], rd_val[0]} !== {2'b11, 16'hFFFF, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h",
               {we_n[0], oe_n[0], dq_obs[0], rd_val[0]}, {2'b11, 16'hFFFF, 32'h0});
    end
    w_en[0] = 1'b0; wb_in[0] = 1'b0;
    #1;
    n_checks++;
    if (frz[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_freeze: got %b expected 0", frz[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    idle(0);
    idle(0);
    n_checks++;
    if ({gi[0].mem[3], gi[0].mem[2]} !== {old[31:16], 16'h5678}) begin
      n_fail++;
      $display("FAIL partial_write: got %h expected %h", {gi[0].mem[3], gi[0].mem[2]},
               {old[31:16], 16'h5678});
    end
    ref_mem[word_key(0, 32'd1028)] = {old[31:16], 16'h5678};
    for (int g = 0; g < NI; g++) ref_rd[g] = 32'h0;
    run_access(0, 1'b1, 1'b0, 32'd1028, 32'h0, 1'b1);
    idle(0);
  endtask

  task automatic test_simultaneous_rw();
    logic [31:0] a;
    a = 32'd1024 + 4 * $urandom_range(300, 400);
    run_access(0, 1'b1, 1'b1, a, $urandom(), 1'b1);
    idle(0);
    run_access(0, 1'b1, 1'b0, a, 32'h0, 1'b0);
    idle(0);
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    d = $urandom();
    run_access(0, 1'b0, 1'b1, 32'd1020, $urandom(), 1'b0);
    idle(0);
    run_access(0, 1'b0, 1'b1, 32'd1024 + 4 * ((1 << 17) + 5), d, 1'b0);
    idle(0);
    run_access(0, 1'b1, 1'b0, 32'd1044, 32'h0, 1'b1);
    idle(0);
    n_checks++;
    if (rd_val[0] !== d) begin
      n_fail++;
      $display("FAIL wrap_alias: got %h expected %h", rd_val[0], d);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [6];
    logic [31:0] a;
    for (int i = 0; i < 6; i++) pool[i] = $urandom();
    for (int n = 0; n < 30; n++) begin
      a = pool[$urandom_range(0, 5)];
      if (ref_mem.exists(word_key(0, a)) && ($urandom_range(0, 1) == 1))
        run_access(0, 1'b1, 1'b0, a, 32'h0, 1'($urandom_range(0, 1)));
      else
        run_access(0, 1'($urandom_range(0, 1)), 1'b1, a, $urandom(), 1'b1);
      if ($urandom_range(0, 1) == 1) idle(0);
    end
    idle(0);
  endtask

  initial begin
    rst = 1'b0;
    for (int g = 0; g < NI; g++) begin
      r_en[g] = 1'b0; w_en[g] = 1'b0; wb_in[g] = 1'b0;
      alu[g] = 32'h0; st[g] = 32'h0; ref_rd[g] = 32'h0;
    end
    @(negedge clk);
    test_reset();
    test_store_load();
    test_wait_sweep();
    test_back_to_back();
    test_reset_mid_access();
    test_simultaneous_rw();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_stage_sram_burst.md
# mem_stage_sram_burst

Parametrised memory stage for the 5-stage MIPS pipeline. It converts a single load/store request from the EX/MEM register into a multi-beat access on an external asynchronous SRAM whose data bus is narrower than the CPU word. A programmable number of wait cycles is inserted per beat. The block freezes the rest of the pipeline until the access completes, then returns the read word and the gated write-back enable to MEM/WB.

## Interface
- DATA_W, 32: CPU word width. Must be a multiple of DQ_W.
- DQ_W, 16: SRAM data bus width.
- ADDR_W, 18: SRAM address bus width.
- WAIT, 1: extra SRAM cycles held per beat, range 0..15.
- BASE_ADDR, 1024: byte address subtracted from alu_result before mapping.
- Derived: BEATS = DATA_W/DQ_W; CYC = BEATS*(WAIT+1).
- clk  in  1  system clock. All state updates on its rising edge.
- rst  in  1  reset. Asynchronous and active-low.
- mem_r_en  in  1  load request.
- mem_w_en  in  1  store request.
- alu_result  in  32  byte address.
- st_val  in  DATA_W  store data.
- wb_en_in  in  1  write-back enable from EX/MEM.
- mem_read_value  out  DATA_W  load result.
- wb_en_out  out  1  write-back enable to MEM/WB.
- freeze  out  1  stall request to all earlier stages and to MEM/WB.
- SRAM_DQ  inout  DQ_W  SRAM data bus.
- SRAM_ADDR  out  ADDR_W  SRAM address.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N  out  1 each  tied to 0 whenever rst is high.
- SRAM_WE_N, SRAM_OE_N  out  1 each  SRAM strobes, active-low.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- Request = mem_r_en | mem_w_en. If both are high, the access is performed as a write.
- IDLE:
  - On request: latch op, word index and st_val; clear beat and wait counters; go to ACCESS.
  - freeze = 1 in this same cycle (combinational from request).
- ACCESS:
  - Holds each beat for WAIT+1 cycles. beat counts 0..BEATS-1; wait counter counts 0..WAIT.
  - SRAM_ADDR = ((alu_result-BASE_ADDR) >> log2(DATA_W/8)) * BEATS + beat, truncated to ADDR_W bits.
  - Beat 0 carries bits DQ_W-1:0 (little-end first).
  - Read: OE_N=0, WE_N=1, DQ tri-stated. The DQ value is captured into lane [beat] on the final wait cycle of that beat.
  - Write: WE_N=0, OE_N=1, DQ driven with st_val slice [beat] for every cycle of the beat.
  - After the last wait cycle of beat BEATS-1, go to DONE.
- DONE:
  - freeze = 0; strobes deasserted; DQ tri-stated.
  - On a read, mem_read_value is updated with the assembled word on entry to DONE.
  - Go to IDLE next cycle. The request input is ignored in DONE, so the pipeline advances without retriggering.
- mem_read_value holds its value until the next read completes; stores do not change it.
- wb_en_out = wb_en_in & ~freeze.
- freeze = (state==IDLE & request) | (state==ACCESS).

## Timing
- Reset values: state IDLE, mem_read_value 0, SRAM_ADDR 0, WE_N 1, OE_N 1, DQ high-Z, freeze 0 (when no request), counters 0.
- Latency: freeze is high for 1+CYC cycles. In the following cycle (DONE), freeze is low and data is valid.
  - Defaults (BEATS=2, WAIT=1): freeze high for 5 cycles; data valid in cycle 6.
- WAIT=0: one cycle per beat; 32/32 configuration gives freeze high for 2 cycles.
- Back-to-back requests: the cycle after DONE is IDLE and accepts a new request immediately. There is no dead cycle beyond DONE.
- Address wrap: the word index wraps modulo 2^ADDR_W/BEATS. No error flag is raised.
- Reset asserted mid-ACCESS: strobes go high and DQ is released asynchronously; the partial read is discarded and mem_read_value is cleared.
- Request deasserted while in ACCESS (illegal, because freeze holds it): the access still completes using the latched values.

## Test plan
- Reset:
  - Stimulus: rst low, then high, with no request.
  - Required: WE_N=OE_N=1, DQ=Z, mem_read_value=0, freeze=0; wb_en_out follows wb_en_in.
- Store then load:
  - Stimulus: store 0xDEADBEEF at alu_result 1028 (defaults).
  - Required: SRAM_ADDR 2 with DQ 0xBEEF, then SRAM_ADDR 3 with DQ 0xDEAD, each with WE_N=0 for 2 cycles; freeze high for 5 cycles.
  - Stimulus: load from 1028.
  - Required: mem_read_value=0xDEADBEEF in the DONE cycle; wb_en_out=1 only in that cycle.
- Wait sweep:
  - Stimulus: WAIT=0 and WAIT=3 on a read.
  - Required: freeze high for 3 and 9 cycles respectively; SRAM model data is returned correctly.
- Back-to-back:
  - Stimulus: a load immediately follows a store.
  - Required: the second access starts the cycle after DONE; total frozen cycles = 10.
- Reset mid-access:
  - Stimulus: pull rst low during beat 1 of a store.
  - Required: WE_N=1 asynchronously; state IDLE; SRAM address 3 is not written after release.
- Simultaneous r/w:
  - Stimulus: mem_r_en=mem_w_en=1.
  - Required: a write cycle occurs; mem_read_value is unchanged.
